// File: rtl/ifetch_queue_if.sv
// Handshake bundle between the fetch queue, instruction memory and decode.
// The slave modport is the fetch unit; the master modport is its environment.
interface ifetch_queue_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport slave (
    output mem_req, mem_addr, instr_valid, instr, instr_pc,
    input  mem_ack, mem_rdata, instr_ready, redirect, redirect_pc
  );

  modport master (
    input  mem_req, mem_addr, instr_valid, instr, instr_pc,
    output mem_ack, mem_rdata, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/ifetch_queue.sv
// Byte-serial instruction fetch with a DEPTH-entry prefetch queue of {instr, pc}.
// Big-endian word assembly; redirect flushes queue and partial word.
module ifetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  ifetch_queue_if.slave bus
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [23:0]   shift_q, shift_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   ent_instr_q [DEPTH];
  logic [31:0]   ent_pc_q    [DEPTH];

  logic          not_full;
  logic          ack_fire;
  logic          push;
  logic          pop;
  logic [31:0]   word_done;

  assign not_full  = (count_q < CW'(DEPTH));
  assign ack_fire  = bus.mem_req & bus.mem_ack;
  assign push      = ack_fire & (byte_cnt_q == 2'd3);
  assign pop       = (count_q != '0) & bus.instr_ready & ~bus.redirect;
  assign word_done = {shift_q, bus.mem_rdata};

  // Request path depends only on registered state plus redirect/reset.
  assign bus.mem_req     = rst_n & ~bus.redirect & not_full;
  assign bus.mem_addr    = fetch_pc_q + {30'd0, byte_cnt_q};
  assign bus.instr_valid = (count_q != '0);
  assign bus.instr       = (count_q != '0) ? ent_instr_q[head_q] : 32'd0;
  assign bus.instr_pc    = (count_q != '0) ? ent_pc_q[head_q]    : 32'd0;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (bus.redirect) begin
      fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
      byte_cnt_d = 2'd0;
      shift_d    = 24'd0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      if (ack_fire) begin
        byte_cnt_d = byte_cnt_q + 2'd1;
        shift_d    = {shift_q[15:0], bus.mem_rdata};
      end
      if (push) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        shift_d    = 24'd0;
        tail_d     = tail_q + PW'(1);
      end
      if (pop) begin
        head_d = head_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      byte_cnt_q <= 2'd0;
      shift_q    <= 24'd0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        ent_instr_q[i] <= 32'd0;
        ent_pc_q[i]    <= 32'd0;
      end
    end else if (push && !bus.redirect) begin
      ent_instr_q[tail_q] <= word_done;
      ent_pc_q[tail_q]    <= fetch_pc_q;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomized and directed checks of ifetch_queue against a queue-based model
// that rebuilds each expected word straight from the memory contents.
module tb_ifetch_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   ack_mode = 0;  // 0 manual, 1 every third cycle, 2 random
  int   cyc = 0;

  ifetch_queue_if bus ();

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [7:0] b;
    case (a)
      32'd0: b = 8'h20;
      32'd1: b = 8'h01;
      32'd2: b = 8'h00;
      32'd3: b = 8'h0A;
      32'd4: b = 8'hAC;
      32'd5: b = 8'h01;
      32'd6: b = 8'h00;
      32'd7: b = 8'h01;
      default: b = (a[7:0] * 8'd37) ^ a[15:8] ^ a[31:24] ^ 8'hC3;
    endcase
    return b;
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {mem_byte(a), mem_byte(a + 32'd1), mem_byte(a + 32'd2), mem_byte(a + 32'd3)};
  endfunction

  assign bus.mem_rdata = mem_byte(bus.mem_addr);

  // Reference model: ordered list of {instr, pc}, next fetch address, bytes taken.
  logic [63:0] mq[$];
  logic [31:0] m_fpc;
  int          m_nb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_fpc = RESET_PC;
    m_nb  = 0;
  endtask

  task automatic model_update();
    logic req;
    logic do_pop;
    if (!rst_n) return;
    if (bus.redirect) begin
      mq.delete();
      m_fpc = {bus.redirect_pc[31:2], 2'b00};
      m_nb  = 0;
      return;
    end
    req    = (mq.size() < DEPTH);
    do_pop = (mq.size() != 0) && bus.instr_ready;
    if (do_pop) void'(mq.pop_front());
    if (req && bus.mem_ack) begin
      m_nb++;
      if (m_nb == 4) begin
        mq.push_back({word_at(m_fpc), m_fpc});
        m_fpc = m_fpc + 32'd4;
        m_nb  = 0;
      end
    end
  endtask

  task automatic compare_model();
    logic        exp_req;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
    exp_req   = rst_n && !bus.redirect && (mq.size() < DEPTH);
    exp_instr = (mq.size() != 0) ? mq[0][63:32] : 32'd0;
    exp_pc    = (mq.size() != 0) ? mq[0][31:0]  : 32'd0;
    chk("mem_req",     {31'd0, bus.mem_req},     {31'd0, exp_req});
    chk("mem_addr",    bus.mem_addr,             m_fpc + 32'(m_nb));
    chk("instr_valid", {31'd0, bus.instr_valid}, {31'd0, mq.size() != 0});
    chk("instr",       bus.instr,                exp_instr);
    chk("instr_pc",    bus.instr_pc,             exp_pc);
  endtask

  // One clock: drive ack per mode, compare on the falling edge, advance model on the rising edge.
  task automatic cycle_step();
    case (ack_mode)
      1: bus.mem_ack = (cyc % 3 == 2);
      2: bus.mem_ack = ($urandom_range(0, 9) < 7);
      default: ;
    endcase
    @(negedge clk);
    compare_model();
    @(posedge clk);
    model_update();
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    bus.mem_ack     = 1'b0;
    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'd0;
    ack_mode        = 0;
    model_reset();
    @(negedge clk);
    compare_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_until_valid(input string tag, input int max_cyc,
                                 input logic [31:0] exp_pc, input logic [31:0] exp_instr);
    for (int i = 0; i < max_cyc; i++) begin
      cycle_step();
      if (bus.instr_valid) begin
        chk({tag, "_pc"},    bus.instr_pc, exp_pc);
        chk({tag, "_instr"}, bus.instr,    exp_instr);
        return;
      end
    end
    chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    bus.mem_ack     = 1'b0;
    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'd0;
    model_reset();

    // Reset values and zero-wait latency.
    do_reset();
    bus.mem_ack = 1'b1;
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle_step();
    chk("lat_not_yet", {31'd0, bus.instr_valid}, 32'd0);
    cycle_step();
    chk("lat_w0_valid", {31'd0, bus.instr_valid}, 32'd1);
    chk("lat_w0_instr", bus.instr, 32'h2001000A);
    chk("lat_w0_pc",    bus.instr_pc, 32'd0);
    for (int i = 0; i < 4; i++) cycle_step();
    chk("lat_w1_instr", bus.instr, 32'hAC010001);
    chk("lat_w1_pc",    bus.instr_pc, 32'd4);
    for (int i = 0; i < 12; i++) cycle_step();

    // Fill to full with decode stalled, then drain.
    do_reset();
    bus.mem_ack = 1'b1;
    for (int i = 0; i < 16; i++) cycle_step();
    chk("full_req",  {31'd0, bus.mem_req}, 32'd0);
    chk("full_addr", bus.mem_addr, 32'd16);
    for (int i = 0; i < 3; i++) cycle_step();
    chk("full_hold_addr", bus.mem_addr, 32'd16);
    chk("full_head_pc", bus.instr_pc, 32'd0);
    bus.instr_ready = 1'b1;
    cycle_step();
    bus.instr_ready = 1'b0;
    chk("resume_req", {31'd0, bus.mem_req}, 32'd1);
    bus.mem_ack = 1'b0;
    for (int i = 1; i < 4; i++) begin
      chk("drain_pc", bus.instr_pc, 32'(4 * i));
      bus.instr_ready = 1'b1;
      cycle_step();
    end
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) cycle_step();

    // Wait states: ack every third cycle.
    do_reset();
    bus.instr_ready = 1'b1;
    ack_mode = 1;
    run_until_valid("wait_w0", 40, 32'd0, 32'h2001000A);
    for (int i = 0; i < 30; i++) cycle_step();

    // Redirect after two acks on word 0.
    do_reset();
    bus.mem_ack = 1'b1;
    bus.instr_ready = 1'b1;
    cycle_step();
    cycle_step();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_0043;
    #1;
    chk("redir_req_low", {31'd0, bus.mem_req}, 32'd0);
    cycle_step();
    bus.redirect = 1'b0;
    chk("redir_empty", {31'd0, bus.instr_valid}, 32'd0);
    chk("redir_addr",  bus.mem_addr, 32'd64);
    run_until_valid("redir_w0", 20, 32'd64, word_at(32'd64));

    // Redirect colliding with pop and a would-be completing ack.
    do_reset();
    bus.mem_ack = 1'b1;
    for (int i = 0; i < 11; i++) cycle_step();
    chk("coll_head_pc", bus.instr_pc, 32'd0);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_0200;
    bus.instr_ready = 1'b1;
    cycle_step();
    bus.redirect = 1'b0;
    bus.instr_ready = 1'b0;
    chk("coll_empty", {31'd0, bus.instr_valid}, 32'd0);
    chk("coll_addr",  bus.mem_addr, 32'h0000_0200);
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) cycle_step();

    // Asynchronous reset mid-word with three words queued.
    do_reset();
    bus.mem_ack = 1'b1;
    for (int i = 0; i < 13; i++) cycle_step();
    chk("pre_rst_pc", bus.instr_pc, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("arst_req",   {31'd0, bus.mem_req},     32'd0);
    chk("arst_addr",  bus.mem_addr,             RESET_PC);
    model_reset();
    @(negedge clk);
    compare_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.instr_ready = 1'b1;
    run_until_valid("arst_w0", 20, RESET_PC, word_at(RESET_PC));

    // Randomized traffic with occasional redirects, including across the address wrap.
    ack_mode = 2;
    for (int i = 0; i < 1500; i++) begin
      bus.instr_ready = (i % 200 < 60) ? 1'b0 : ($urandom_range(0, 1) == 1);
      bus.redirect    = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 3) == 0) bus.redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else                           bus.redirect_pc = $urandom;
      cycle_step();
    end
    bus.redirect = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
Byte-serial instruction fetch unit with a prefetch queue, sitting directly upstream of the decode/control stage of the MIPS core. It walks a byte-addressed, big-endian instruction memory one byte per handshake and assembles 32-bit instruction words. It buffers each word with its PC and presents them in order to decode over a valid/ready handshake. Branch and jump targets computed downstream redirect it, which flushes all fetched and partial state.

Parameters:
DEPTH, 4, number of queue entries; power of two, at least 2.
RESET_PC, 32'h00000000, fetch address after reset; bits [1:0] must be 0.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  asynchronous active-low reset.
mem_req  out  1  byte read request to instruction memory.
mem_addr  out  32  byte address of the request; equals fetch_pc + byte_cnt.
mem_ack  in  1  memory accepts the request; mem_rdata is valid in the same cycle.
mem_rdata  in  8  byte read from mem_addr.
instr_valid  out  1  queue head holds a valid instruction.
instr_ready  in  1  decode consumes the head on a clock edge where valid and ready are both 1.
instr  out  32  instruction word at the queue head.
instr_pc  out  32  byte address of instr.
redirect  in  1  flush and restart fetching at redirect_pc.
redirect_pc  in  32  new fetch address; bits [1:0] are ignored and treated as 0.

Behaviour:
- Single clock domain, clk. Reset is asynchronous, active-low on rst_n. All state is cleared on the falling edge of rst_n, regardless of clk.
- Reset values:
  - fetch_pc = RESET_PC; byte_cnt = 0; count = 0; head and tail pointers = 0.
  - mem_req = 0; mem_addr = RESET_PC; instr_valid = 0; instr = 0; instr_pc = 0.
- Internal state:
  - fetch_pc: word-aligned PC of the word being assembled.
  - byte_cnt: 2 bits, from 0 to 3.
  - word shift register.
  - Queue of DEPTH entries, each holding {instr, pc}, with a count from 0 to DEPTH.
- mem_req is combinational: rst_n & !redirect & (count < DEPTH). The one word being assembled always has a free slot reserved, because pops only lower count.
- Byte assembly is big-endian. A byte at fetch_pc+0 lands in [31:24], +1 in [23:16], +2 in [15:8], +3 in [7:0].
- Each mem_req & mem_ack edge stores the byte and increments byte_cnt.
  - On the ack with byte_cnt==3, push {word, fetch_pc} at the tail, set fetch_pc += 4, and reset byte_cnt to 0.
  - fetch_pc wraps from 32'hFFFFFFFC to 0.
- mem_ack while mem_req==0 is ignored.
- Latency with zero-wait memory (ack in every requesting cycle):
  - The first request is in the first cycle after reset is released.
  - The word is pushed at the end of the 4th ack cycle.
  - instr_valid is 1 in the following cycle.
  - Sustained throughput is 1 word per 4 cycles.
- Outputs:
  - instr_valid = (count != 0).
  - instr and instr_pc show the head entry, and are 0 when the queue is empty.
  - Outputs are driven combinationally from the registered queue; there is no memory-to-decode combinational path.
- Pop happens on instr_valid & instr_ready. The head pointer advances modulo DEPTH.
- Simultaneous push and pop: count is unchanged and both pointers advance. This is legal when count==DEPTH only if the word just completed; it cannot happen because no request is made while full.
- Full (count==DEPTH): mem_req=0; byte_cnt and the partial word are held. Fetching resumes in the cycle after a pop.
- Empty: instr_valid=0; instr_ready is ignored.
- Redirect has the highest priority after reset. On an edge with redirect=1:
  - count and both pointers are cleared to 0; byte_cnt and the partial word are cleared.
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - Any concurrent pop is void, and any concurrent push is discarded.
  - mem_req is 0 during the redirect cycle; a mem_ack in that cycle is ignored.
- After a redirect, instr_valid is 0 until a new word completes from the new fetch_pc. The first request goes out in the cycle after redirect deasserts.
- Back-to-back redirects: the last one wins; no fetch happens in between.
- Reset asserted mid-word or mid-queue: all contents are lost immediately. After release, fetch restarts at RESET_PC.

Test Plan:
- Memory bytes 0..7 = 20 01 00 0A AC 01 00 01, zero-wait ack, instr_ready=1 -> instr=32'h2001000A, instr_pc=0 is valid on the cycle after the 4th ack. Then instr=32'hAC010001, instr_pc=4 appears exactly 4 cycles later.
- Same memory, instr_ready=0, DEPTH=4 -> after 16 acks count=4 and mem_req=0 with mem_addr=16 held. Raise instr_ready for 1 cycle -> mem_req=1 the next cycle. Pops return PCs 0,4,8,12 in order.
- Wait states: ack only every 3rd cycle -> the word is still 32'h2001000A. mem_addr stays stable while mem_ack=0.
- After 2 acks on word 0, pulse redirect with redirect_pc=32'h00000043 -> queue is empty and mem_req=0 in the redirect cycle. Next mem_addr=64, and the first valid instr_pc=64 holds bytes 64..67. The partial word is never output.
- Queue holds 2 entries while redirect, instr_ready, and a completing 4th ack all occur in the same cycle -> count=0 afterwards, no output for the old entries, fetch_pc=redirect target.
- Deassert rst_n asynchronously mid-word with count=3 -> instr_valid=0 and mem_req=0 immediately, without waiting for clk. After release, mem_addr=RESET_PC and the first output is the word at RESET_PC.
